multi_channel_averager: RTL and testbench

//  Parametrised N-channel signed averager; successor to the fixed 4-axis accelerometer averager.

---
 rtl/multi_channel_averager.sv | 155 +++++++++++++++
 tb/tb_multi_channel_averager.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/multi_channel_averager.sv
// N-channel signed block/sliding-window averager with a 3-stage pipeline (in -> acc -> out).
// Optional macro AVG_ROUND_EN selects round-half-up averaging instead of floor.
module multi_channel_averager #(
    parameter int NUM_CH     = 4,
    parameter int DATA_WIDTH = 19,
    parameter int LOG2_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_AVG_Valid,
    input  logic [NUM_CH*DATA_WIDTH-1:0] i_AVG_Data,
    input  logic                         i_AVG_Mode,
    input  logic                         i_AVG_Clear,
    output logic [NUM_CH*DATA_WIDTH-1:0] o_AVG_Data,
    output logic                         o_AVG_Valid,
    output logic                         o_AVG_Full,
    output logic [LOG2_DEPTH:0]          o_AVG_Count
);

    localparam int DEPTH = 1 << LOG2_DEPTH;
    localparam int AW    = DATA_WIDTH + LOG2_DEPTH;
    localparam int BW    = NUM_CH * DATA_WIDTH;

    typedef enum logic {StFill, StRun} state_t;

    logic                   r_s0_valid;
    logic                   r_s0_mode;
    logic [BW-1:0]          r_s0_data;
    logic                   r_mode;
    state_t                 r_state;
    logic [LOG2_DEPTH-1:0]  r_wptr;
    logic [LOG2_DEPTH:0]    r_count;
    logic                   r_full;
    logic                   r_emit;
    logic signed [AW-1:0]   r_acc [NUM_CH];
    logic signed [AW-1:0]   r_sum [NUM_CH];
    logic [BW-1:0]          r_ring [DEPTH];

    logic                   w_flush;
    logic [BW-1:0]          w_old;
    logic signed [AW-1:0]   w_new [NUM_CH];
    logic signed [AW-1:0]   w_old_ch [NUM_CH];
    logic signed [AW-1:0]   w_acc_add [NUM_CH];
    logic signed [AW-1:0]   w_acc_slide [NUM_CH];
    logic [BW-1:0]          w_avg;
`ifdef AVG_ROUND_EN
    logic signed [AW:0]     w_rnd [NUM_CH];
`endif

    // A registered mode that disagrees with the active mode flushes just like an explicit clear.
    assign w_flush = i_AVG_Clear | (r_s0_mode != r_mode);
    assign w_old   = r_ring[r_wptr];

    always_comb begin
        w_avg = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_new[c]    = {{LOG2_DEPTH{r_s0_data[c*DATA_WIDTH+DATA_WIDTH-1]}},
                           r_s0_data[c*DATA_WIDTH +: DATA_WIDTH]};
            w_old_ch[c] = {{LOG2_DEPTH{w_old[c*DATA_WIDTH+DATA_WIDTH-1]}},
                           w_old[c*DATA_WIDTH +: DATA_WIDTH]};
            w_acc_add[c]   = r_acc[c] + w_new[c];
            w_acc_slide[c] = w_acc_add[c] - w_old_ch[c];
`ifdef AVG_ROUND_EN
            w_rnd[c] = {r_sum[c][AW-1], r_sum[c]} + (AW+1)'(DEPTH / 2);
            w_avg[c*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(w_rnd[c] >>> LOG2_DEPTH);
`else
            w_avg[c*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(r_sum[c] >>> LOG2_DEPTH);
`endif
        end
    end

    // Ring contents are don't-care after reset, so the memory carries no reset.
    always_ff @(posedge clk) begin
        if (r_s0_valid && !w_flush) begin
            r_ring[r_wptr] <= r_s0_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s0_valid  <= 1'b0;
            r_s0_mode   <= 1'b0;
            r_s0_data   <= '0;
            r_mode      <= 1'b0;
            r_state     <= StFill;
            r_wptr      <= '0;
            r_count     <= '0;
            r_full      <= 1'b0;
            r_emit      <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                r_acc[c] <= '0;
                r_sum[c] <= '0;
            end
            o_AVG_Data  <= '0;
            o_AVG_Valid <= 1'b0;
            o_AVG_Full  <= 1'b0;
            o_AVG_Count <= '0;
        end else begin
            r_s0_valid <= i_AVG_Valid & ~i_AVG_Clear;
            r_s0_mode  <= i_AVG_Mode;
            r_s0_data  <= i_AVG_Data;

            if (w_flush) begin
                r_mode  <= r_s0_mode;
                r_state <= StFill;
                r_wptr  <= '0;
                r_count <= '0;
                r_full  <= 1'b0;
                r_emit  <= 1'b0;
                for (int c = 0; c < NUM_CH; c++) begin
                    r_acc[c] <= '0;
                end
            end else begin
                r_emit <= 1'b0;
                if (r_s0_valid) begin
                    r_wptr <= r_wptr + 1'b1;
                    if (r_state == StRun) begin
                        r_emit <= 1'b1;
                        for (int c = 0; c < NUM_CH; c++) begin
                            r_acc[c] <= w_acc_slide[c];
                            r_sum[c] <= w_acc_slide[c];
                        end
                    end else if (r_count == (LOG2_DEPTH+1)'(DEPTH - 1)) begin
                        r_emit <= 1'b1;
                        for (int c = 0; c < NUM_CH; c++) begin
                            r_sum[c] <= w_acc_add[c];
                            r_acc[c] <= r_mode ? w_acc_add[c] : '0;
                        end
                        if (r_mode) begin
                            r_state <= StRun;
                            r_full  <= 1'b1;
                            r_count <= (LOG2_DEPTH+1)'(DEPTH);
                        end else begin
                            r_count <= '0;
                        end
                    end else begin
                        r_count <= r_count + 1'b1;
                        for (int c = 0; c < NUM_CH; c++) begin
                            r_acc[c] <= w_acc_add[c];
                        end
                    end
                end
            end

            // Full/Count are delayed one stage so Full rises together with the first pulse.
            o_AVG_Valid <= r_emit & ~w_flush;
            o_AVG_Full  <= r_full & ~w_flush;
            o_AVG_Count <= w_flush ? '0 : r_count;
            if (r_emit && !w_flush) begin
                o_AVG_Data <= w_avg;
            end
        end
    end

endmodule

// File: tb/tb_multi_channel_averager.sv
// Scoreboard bench for multi_channel_averager (2 channels, 12 bits, depth 4).
module tb_multi_channel_averager;

    localparam int NCH = 2;
    localparam int DW  = 12;
    localparam int LD  = 2;

    logic              clk;
    logic              reset;
    logic              i_valid;
    logic [NCH*DW-1:0] i_data;
    logic              i_mode;
    logic              i_clear;
    logic [NCH*DW-1:0] o_data;
    logic              o_valid;
    logic              o_full;
    logic [LD:0]       o_count;

    logic signed [DW-1:0] o_ch0;
    logic signed [DW-1:0] o_ch1;
    assign o_ch0 = o_data[DW-1:0];
    assign o_ch1 = o_data[2*DW-1:DW];

    typedef struct {
        int e0;
        int e1;
        int ef;
        int cyc;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    multi_channel_averager #(
        .NUM_CH(NCH),
        .DATA_WIDTH(DW),
        .LOG2_DEPTH(LD)
    ) dut (
        .clk(clk),
        .reset(reset),
        .i_AVG_Valid(i_valid),
        .i_AVG_Data(i_data),
        .i_AVG_Mode(i_mode),
        .i_AVG_Clear(i_clear),
        .o_AVG_Data(o_data),
        .o_AVG_Valid(o_valid),
        .o_AVG_Full(o_full),
        .o_AVG_Count(o_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
        end
    endtask

    task automatic send(input int a, input int b, input bit clr, input bit ex,
                        input int e0, input int e1, input int ef);
        exp_t e;
        @(negedge clk);
        i_valid = 1'b1;
        i_clear = clr;
        i_data  = {b[DW-1:0], a[DW-1:0]};
        if (ex) begin
            e.e0  = e0;
            e.e1  = e1;
            e.ef  = ef;
            e.cyc = cyc + 3;
            q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            i_valid = 1'b0;
            i_clear = 1'b0;
        end
    endtask

    // Monitor: every output pulse must match the oldest expected entry, including its timing.
    always @(negedge clk) begin
        if (o_valid) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pulse: got ch0=%0d ch1=%0d expected no pulse",
                         o_ch0, o_ch1);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("pulse_ch0", int'(o_ch0), e.e0);
                chk("pulse_ch1", int'(o_ch1), e.e1);
                chk("pulse_full", int'(o_full), e.ef);
                chk("pulse_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        int wait_n;
        reset   = 1'b1;
        i_valid = 1'b0;
        i_clear = 1'b0;
        i_mode  = 1'b0;
        i_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_data", int'(o_data), 0);
        chk("reset_valid", int'(o_valid), 0);
        chk("reset_full", int'(o_full), 0);
        chk("reset_count", int'(o_count), 0);
        @(negedge clk);
        reset = 1'b0;
        idle(2);

        // Block mode: 1..4 and -8 constant
        send(1, -8, 0, 0, 0, 0, 0);
        send(2, -8, 0, 0, 0, 0, 0);
        send(3, -8, 0, 0, 0, 0, 0);
`ifdef AVG_ROUND_EN
        send(4, -8, 0, 1, 3, -8, 0);
`else
        send(4, -8, 0, 1, 2, -8, 0);
`endif
        idle(4);
        chk("block_count_zero", int'(o_count), 0);

        // Negative sum -5
        send(-1, 0, 0, 0, 0, 0, 0);
        send(-1, 0, 0, 0, 0, 0, 0);
        send(-1, 0, 0, 0, 0, 0, 0);
`ifdef AVG_ROUND_EN
        send(-2, 0, 0, 1, -1, 0, 0);
`else
        send(-2, 0, 0, 1, -2, 0, 0);
`endif
        idle(3);

        // Extremes
        for (int i = 0; i < 4; i++) send(2047, -2048, 0, (i == 3), 2047, -2048, 0);
        for (int i = 0; i < 4; i++) send(-2048, 2047, 0, (i == 3), -2048, 2047, 0);
        idle(4);

        // Clear together with a strobe flushes the partial window
        for (int i = 0; i < 3; i++) send(9, 9, 0, 0, 0, 0, 0);
        idle(3);
        chk("partial_count", int'(o_count), 3);
        send(9, 9, 1, 0, 0, 0, 0);
        idle(3);
        chk("clear_count", int'(o_count), 0);
        for (int i = 0; i < 4; i++) send(5, -5, 0, (i == 3), 5, -5, 0);
        idle(4);

        // Mode toggle mid-window flushes, then sliding mode
        send(7, 7, 0, 0, 0, 0, 0);
        send(7, 7, 0, 0, 0, 0, 0);
        idle(3);
        i_mode = 1'b1;
        idle(4);
        chk("mode_flush_count", int'(o_count), 0);
        send(4, -4, 0, 0, 0, 0, 0);
        send(8, -4, 0, 0, 0, 0, 0);
        send(12, -4, 0, 0, 0, 0, 0);
        chk("full_before_first", int'(o_full), 0);
        send(16, -4, 0, 1, 10, -4, 1);
        send(20, -4, 0, 1, 14, -4, 1);
        send(24, -4, 0, 1, 18, -4, 1);
        idle(4);
        chk("slide_full", int'(o_full), 1);
        chk("slide_count", int'(o_count), 4);
        chk("hold_data", int'(o_ch0), 18);

        // Asynchronous reset in RUN between strobes
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("midreset_data", int'(o_data), 0);
        chk("midreset_valid", int'(o_valid), 0);
        chk("midreset_full", int'(o_full), 0);
        chk("midreset_count", int'(o_count), 0);
        @(negedge clk);
        reset = 1'b0;
        idle(4);
        for (int i = 0; i < 3; i++) send(6, 1, 0, 0, 0, 0, 0);
        idle(4);
        chk("post_reset_full", int'(o_full), 0);
        chk("post_reset_count", int'(o_count), 3);
        send(6, 1, 0, 1, 6, 1, 1);
        idle(2);

        wait_n = 0;
        while (q.size() != 0 && wait_n < 20) begin
            @(negedge clk);
            wait_n++;
        end
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL missing_pulses: got %0d outstanding expected 0", q.size());
        end
        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
